// File: rtl/vga_pkg.sv
// vga_pkg -- shared VGA timing constants, colour type and colour helpers for
// the note compositor.
//
// Contents:
//   H_ACTIVE / V_ACTIVE     visible raster size (640 x 480)
//   rgb_t                   24-bit packed colour {r, g, b}
//   COL_*                   lane colours, separator grey, background grey,
//                           black, white
//   lane_colour()           lane index (mod 4) -> lane colour
//   blend_half()            per-channel 50% blend (a>>1)+(b>>1)
package vga_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_GREEN  = {8'd0,   8'd255, 8'd0};
    localparam rgb_t COL_RED    = {8'd255, 8'd0,   8'd0};
    localparam rgb_t COL_YELLOW = {8'd255, 8'd255, 8'd0};
    localparam rgb_t COL_BLUE   = {8'd0,   8'd0,   8'd255};
    localparam rgb_t COL_WHITE  = {8'd255, 8'd255, 8'd255};
    localparam rgb_t COL_SEP    = {8'd64,  8'd64,  8'd64};
    localparam rgb_t COL_BG     = {8'd16,  8'd16,  8'd16};
    localparam rgb_t COL_BLACK  = {8'd0,   8'd0,   8'd0};

    // Lane colours repeat every four lanes, so only the low two bits matter.
    function automatic rgb_t lane_colour(input logic [1:0] sel);
        rgb_t c;
        case (sel)
            2'd0:    c = COL_GREEN;
            2'd1:    c = COL_RED;
            2'd2:    c = COL_YELLOW;
            2'd3:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

    // Halving both operands first keeps the sum inside 8 bits (max 254).
    function automatic rgb_t blend_half(input rgb_t a, input rgb_t b);
        rgb_t c;
        c.r = {1'b0, a.r[7:1]} + {1'b0, b.r[7:1]};
        c.g = {1'b0, a.g[7:1]} + {1'b0, b.g[7:1]};
        c.b = {1'b0, a.b[7:1]} + {1'b0, b.b[7:1]};
        return c;
    endfunction

endpackage

// File: rtl/lane_flash_ctr.sv
// lane_flash_ctr -- one lane's hit-flash timer, counted in frames.
//
// Ports:
//   clk_i    pixel clock
//   rst_i    asynchronous active-high reset (counter -> 0)
//   load_i   hit strobe: reload the counter with FLASH_FRAMES (wins over dec_i)
//   dec_i    frame tick: decrement, saturating at 0
//   flash_o  high while the counter is non-zero
module lane_flash_ctr #(
    parameter int FLASH_FRAMES = 8,
    parameter int CW           = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic flash_o
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(FLASH_FRAMES);
    localparam logic [CW-1:0] ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: a hit reload has priority over the frame decrement.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (dec_i && (count_q != ZERO)) begin
            count_d = count_q - ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign flash_o = (count_q != ZERO);

endmodule

// File: rtl/note_compositor.sv
// note_compositor -- pixel colour stage between the lane pattern generators
// and the VGA controller.
//
// Ports:
//   CLOCK_25     pixel clock
//   reset        asynchronous active-high reset
//   next_x/y     pixel requested by the VGA controller (10 bits each)
//   note_valid   per-lane "note visible" flags
//   note_y       per-lane note top in units of 2 rows, lane i at [8i+7:8i]
//   hit_pulse    per-lane one-cycle hit strobe
//   R_out/G_out/B_out  registered pixel colour, 2 cycles after the request
//   frame_start  one-cycle pulse, the frame tick delayed by one cycle
//
// The frame tick is the request of pixel (0,480), the first blanking line.
// Note state is copied into shadow registers on that tick, so a frame is
// always drawn from a single consistent snapshot.
//
// Build option: define NOTE_BLEND_EN to draw notes as 50% blends over the
// separator/background colour instead of opaque.
module note_compositor
    import vga_pkg::*;
#(
    parameter int N_LANES      = 4,
    parameter int LANE_X0      = 160,
    parameter int LANE_W       = 80,
    parameter int NOTE_H       = 16,
    parameter int HIT_Y        = 440,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                   CLOCK_25,
    input  logic                   reset,
    input  logic [9:0]             next_x,
    input  logic [9:0]             next_y,
    input  logic [N_LANES-1:0]     note_valid,
    input  logic [8*N_LANES-1:0]   note_y,
    input  logic [N_LANES-1:0]     hit_pulse,
    output logic [7:0]             R_out,
    output logic [7:0]             G_out,
    output logic [7:0]             B_out,
    output logic                   frame_start
);

    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int CW = $clog2(FLASH_FRAMES + 1);

    localparam logic [9:0] X_START = 10'(LANE_X0);
    localparam logic [9:0] X_END   = 10'(LANE_X0 + N_LANES * LANE_W);
    localparam logic [9:0] HIT_Y0  = 10'(HIT_Y);
    localparam logic [9:0] HIT_Y1  = 10'(HIT_Y + 1);
    localparam logic [9:0] NOTE_HV = 10'(NOTE_H);

    // ---------------------------------------------------------------- tick
    logic tick_s;
    logic frame_start_q;
    logic [N_LANES-1:0]   shadow_valid_q;
    logic [8*N_LANES-1:0] shadow_y_q;

    assign tick_s = (next_x == 10'd0) && (next_y == V_ACTIVE);

    // Frame pulse and once-per-frame note snapshot.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            frame_start_q  <= 1'b0;
            shadow_valid_q <= {N_LANES{1'b0}};
            shadow_y_q     <= {(8*N_LANES){1'b0}};
        end else begin
            frame_start_q <= tick_s;
            if (tick_s) begin
                shadow_valid_q <= note_valid;
                shadow_y_q     <= note_y;
            end
        end
    end

    assign frame_start = frame_start_q;

    // ---------------------------------------------------------- hit flash
    logic [N_LANES-1:0] flash_s;

    for (genvar i = 0; i < N_LANES; i++) begin : g_flash
        lane_flash_ctr #(
            .FLASH_FRAMES (FLASH_FRAMES),
            .CW           (CW)
        ) u_flash (
            .clk_i   (CLOCK_25),
            .rst_i   (reset),
            .load_i  (hit_pulse[i]),
            .dec_i   (tick_s),
            .flash_o (flash_s[i])
        );
    end

    // ------------------------------------------------------------ stage 1
    logic          active_d,  active_q;
    logic          in_lane_d, in_lane_q;
    logic          sep_d,     sep_q;
    logic [LW-1:0] lane_d,    lane_q;
    logic [9:0]    y_q;

    // Column decode: lane index by a compare chain against each lane's left
    // edge; the separator flag also covers the right edge of the last lane.
    always_comb begin
        active_d  = (next_x < H_ACTIVE) && (next_y < V_ACTIVE);
        in_lane_d = (next_x >= X_START) && (next_x < X_END);
        lane_d    = {LW{1'b0}};
        sep_d     = 1'b0;
        for (int k = 1; k < N_LANES; k++) begin
            lane_d = (next_x >= 10'(LANE_X0 + k * LANE_W)) ? LW'(k) : lane_d;
        end
        for (int k = 0; k <= N_LANES; k++) begin
            sep_d = sep_d | (next_x == 10'(LANE_X0 + k * LANE_W));
        end
    end

    // Stage 1 pipeline registers.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            active_q  <= 1'b0;
            in_lane_q <= 1'b0;
            sep_q     <= 1'b0;
            lane_q    <= {LW{1'b0}};
            y_q       <= 10'd0;
        end else begin
            active_q  <= active_d;
            in_lane_q <= in_lane_d;
            sep_q     <= sep_d;
            lane_q    <= lane_d;
            y_q       <= next_y;
        end
    end

    // ------------------------------------------------------------ stage 2
    logic [LW+1:0] lane_ext_s;
    logic [9:0]    note_top_s;
    logic [9:0]    note_end_s;
    logic          note_s;
    logic          hit_row_s;
    rgb_t          lane_col_s;
    rgb_t          under_s;
    rgb_t          note_col_s;
    rgb_t          pix_d;
    rgb_t          pix_q;

    assign lane_ext_s = {2'b00, lane_q};
    assign lane_col_s = lane_colour(lane_ext_s[1:0]);

    // Note rows are 2*note_y .. 2*note_y+NOTE_H-1; 10-bit maths cannot wrap
    // (max 510+16), and rows past 479 are dropped by the active check.
    assign note_top_s = {1'b0, shadow_y_q[{lane_q, 3'b000} +: 8], 1'b0};
    assign note_end_s = note_top_s + NOTE_HV;
    assign note_s     = in_lane_q && shadow_valid_q[lane_q] &&
                        (y_q >= note_top_s) && (y_q < note_end_s);
    assign hit_row_s  = (y_q == HIT_Y0) || (y_q == HIT_Y1);

    // Colour underneath a note: separator grey, lane background or black.
    always_comb begin
        under_s = COL_BLACK;
        if (sep_q) begin
            under_s = COL_SEP;
        end else if (in_lane_q) begin
            under_s = COL_BG;
        end else begin
            under_s = COL_BLACK;
        end
    end

    // Note pixel colour: opaque lane colour, or a half blend with the
    // underlying colour when blending is built in.
    always_comb begin
`ifdef NOTE_BLEND_EN
        note_col_s = blend_half(lane_col_s, under_s);
`else
        note_col_s = lane_col_s;
`endif
    end

    // Colour priority: blanking, hit line, note, separator/background.
    always_comb begin
        pix_d = COL_BLACK;
        if (!active_q) begin
            pix_d = COL_BLACK;
        end else if (hit_row_s && in_lane_q) begin
            if (flash_s[lane_q]) begin
                pix_d = lane_col_s;
            end else begin
                pix_d = COL_WHITE;
            end
        end else if (note_s) begin
            pix_d = note_col_s;
        end else begin
            pix_d = under_s;
        end
    end

    // Registered colour output.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            pix_q <= COL_BLACK;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign R_out = pix_q.r;
    assign G_out = pix_q.g;
    assign B_out = pix_q.b;

endmodule

// File: tb/tb_note_compositor.sv
// Directed bench for note_compositor: reset, frame snapshot, note drawing,
// hit-flash timing, column decode and optional note blending.
module tb_note_compositor;

    logic        CLOCK_25 = 1'b0;
    logic        reset;
    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic [3:0]  note_valid;
    logic [31:0] note_y;
    logic [3:0]  hit_pulse;
    logic [7:0]  R_out;
    logic [7:0]  G_out;
    logic [7:0]  B_out;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [23:0] C_BLACK = 24'h000000;
    localparam logic [23:0] C_BG    = 24'h101010;
    localparam logic [23:0] C_SEP   = 24'h404040;
    localparam logic [23:0] C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_YEL   = 24'hFFFF00;
`ifdef NOTE_BLEND_EN
    localparam logic [23:0] N_GRN = 24'h088708;   // (0>>1)+8, (255>>1)+8, 8
    localparam logic [23:0] N_RED = 24'h870808;
    localparam logic [23:0] N_YEL = 24'h878708;
    localparam logic [23:0] N_BLU = 24'h080887;
`else
    localparam logic [23:0] N_GRN = 24'h00FF00;
    localparam logic [23:0] N_RED = 24'hFF0000;
    localparam logic [23:0] N_YEL = 24'hFFFF00;
    localparam logic [23:0] N_BLU = 24'h0000FF;
`endif

    note_compositor dut (
        .CLOCK_25    (CLOCK_25),
        .reset       (reset),
        .next_x      (next_x),
        .next_y      (next_y),
        .note_valid  (note_valid),
        .note_y      (note_y),
        .hit_pulse   (hit_pulse),
        .R_out       (R_out),
        .G_out       (G_out),
        .B_out       (B_out),
        .frame_start (frame_start)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    task automatic check_eq(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
        end
    endtask

    // Request one pixel and compare the colour two clock edges later.
    task automatic px(input int x, input int y, input logic [23:0] exp, input string tag);
        @(negedge CLOCK_25);
        next_x = 10'(x);
        next_y = 10'(y);
        @(negedge CLOCK_25);
        @(negedge CLOCK_25);
        check_eq(tag, {R_out, G_out, B_out}, exp);
        next_x = 10'd700;
        next_y = 10'd10;
    endtask

    // One-cycle frame tick; frame_start must follow one cycle later.
    task automatic tick(input logic [3:0] hits);
        @(negedge CLOCK_25);
        next_x    = 10'd0;
        next_y    = 10'd480;
        hit_pulse = hits;
        @(negedge CLOCK_25);
        hit_pulse = 4'b0000;
        next_x    = 10'd700;
        next_y    = 10'd10;
        check_eq("frame_start_hi", {23'd0, frame_start}, 24'd1);
    endtask

    task automatic hit(input logic [3:0] hits);
        @(negedge CLOCK_25);
        hit_pulse = hits;
        @(negedge CLOCK_25);
        hit_pulse = 4'b0000;
    endtask

    initial begin
        reset      = 1'b1;
        next_x     = 10'd700;
        next_y     = 10'd10;
        note_valid = 4'b0000;
        note_y     = 32'd0;
        hit_pulse  = 4'b0000;
        repeat (3) @(negedge CLOCK_25);
        check_eq("reset_rgb", {R_out, G_out, B_out}, C_BLACK);
        check_eq("reset_fs", {23'd0, frame_start}, 24'd0);
        reset = 1'b0;

        // Lane 1 note at rows 200..215; nothing drawn before the first tick.
        note_valid = 4'b0010;
        note_y     = {8'd0, 8'd0, 8'd100, 8'd0};
        px(260, 200, C_BG, "pre_tick_no_note");
        tick(4'b0000);
        @(negedge CLOCK_25);
        check_eq("frame_start_lo", {23'd0, frame_start}, 24'd0);
        px(260, 200, N_RED, "note_top");
        px(260, 215, N_RED, "note_last_row");
        px(260, 216, C_BG,  "note_below");
        px(260, 199, C_BG,  "note_above");

        // Mid-frame change must wait for the next tick.
        note_y = {8'd0, 8'd0, 8'd50, 8'd0};
        px(260, 200, N_RED, "snapshot_hold");
        px(260, 100, C_BG,  "snapshot_new_hidden");
        tick(4'b0000);
        px(260, 100, N_RED, "snapshot_new");
        px(260, 200, C_BG,  "snapshot_old_gone");

        // Column decode.
        px(160, 300, C_SEP,   "sep_lane0");
        px(480, 300, C_SEP,   "sep_right_edge");
        px(240, 300, C_SEP,   "sep_lane1");
        px(100, 300, C_BLACK, "left_of_lanes");
        px(700, 10,  C_BLACK, "inactive_x");
        px(479, 300, C_BG,    "last_lane_col");

        // Hit line without flash, and outside the lanes.
        px(200, 441, C_WHITE, "hitline_white");
        px(100, 440, C_BLACK, "hitline_outside");

        // Lane 2 flash: 8 frames yellow, then white.
        hit(4'b0100);
        px(360, 440, C_YEL, "flash_start");
        for (int k = 1; k <= 8; k++) begin
            tick(4'b0000);
            px(360, 440, (k < 8) ? C_YEL : C_WHITE, $sformatf("flash_frame%0d", k));
        end

        // Hit coinciding with the tick: load wins over decrement.
        tick(4'b0100);
        for (int k = 1; k <= 8; k++) begin
            tick(4'b0000);
            if (k >= 7) begin
                px(360, 441, (k < 8) ? C_YEL : C_WHITE, $sformatf("reload_frame%0d", k));
            end
        end

        // Other lane colours and bottom clipping.
        note_valid = 4'b1111;
        note_y     = {8'd30, 8'd236, 8'd50, 8'd20};
        tick(4'b0000);
        px(180, 40,  N_GRN,   "lane0_note");
        px(420, 75,  N_BLU,   "lane3_note");
        px(330, 479, N_YEL,   "lane2_note_clip_in");
        px(330, 480, C_BLACK, "lane2_note_clip_out");

        // Reset mid-line clears output, flash and shadows.
        hit(4'b0100);
        px(160, 300, C_SEP, "pre_reset_sep");
        @(negedge CLOCK_25);
        reset = 1'b1;
        @(posedge CLOCK_25);
        #1;
        check_eq("midreset_rgb", {R_out, G_out, B_out}, C_BLACK);
        check_eq("midreset_fs", {23'd0, frame_start}, 24'd0);
        @(negedge CLOCK_25);
        reset = 1'b0;
        px(260, 100, C_BG,    "post_reset_no_note");
        px(360, 440, C_WHITE, "post_reset_no_flash");
        tick(4'b0000);
        px(260, 100, N_RED,   "post_reset_note");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
